// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two valid/ready requesters.
// Latency: rsp_valid rises two cycles after the accept edge; at most one operation per 3 cycles.
// Backpressure: rsp_ready low parks the FSM in RESP; both requester readies stay low meanwhile.
// Build option: define ALU_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 wins); default round-robin.
module alu_arbiter #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 3,
  parameter int OUT_W  = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [OUT_W-1:0]  alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [OUT_W-1:0]  rsp_out,
  output logic              busy,
  output logic [7:0]        op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   pref;    // requester favoured when both (or neither) are valid
  logic   pick;    // requester that ready points at while idle
  logic   accept;  // request handshake this cycle
  logic   owner;   // requester whose operation is in flight
  logic   rsp_done;

  assign rsp_done = (state == RESP) && rsp_ready;
  assign busy     = (state != IDLE);

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  assign pref = 1'b0;
`else
  logic last_grant;

  assign pref = ~last_grant;

  // Remember who was served last; reset to 1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           last_grant <= 1'b1;
    else if (rsp_done) last_grant <= rsp_id;
  end
`endif

  // Arbitration: a lone valid requester always wins, otherwise the preferred one.
  always_comb begin
    pick = pref;
    if (req0_valid && !req1_valid)      pick = 1'b0;
    else if (req1_valid && !req0_valid) pick = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and requester readies; readies are only ever raised in IDLE.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = ~pick;
        req1_ready = pick;
        accept     = pick ? req1_valid : req0_valid;
        if (accept) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept; the ALU inputs hold their last values afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      owner   <= 1'b0;
    end else if (accept) begin
      alu_a   <= pick ? req1_a   : req0_a;
      alu_b   <= pick ? req1_b   : req0_b;
      alu_sel <= pick ? req1_sel : req0_sel;
      owner   <= pick;
    end
  end

  // Result capture in EXEC, response hold in RESP, completion counting on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      op_count  <= 8'd0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= owner;
      rsp_out   <= alu_out;
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
      op_count  <= op_count + 8'd1;
    end
  end

endmodule
